// File: rtl/apb_reg_responder.sv
// APB responder: decodes one Pselx bit, serves a small 32-bit register bank, counts transfers, flags protocol errors.
// Latency: zero wait states; read data/error registered at the setup->access edge, writes commit at the end of access.
// Backpressure: none; the responder never stalls the bus and always completes an access cycle in one clock.
module apb_reg_responder #(
  parameter int SEL_IDX  = 0,
  parameter int NUM_REGS = 8
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pslverr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        proto_err,
  input  logic        err_clr
);

  // Register index width; the bank is a power of two so the index is a plain slice.
  localparam int IW = $clog2(NUM_REGS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;

  logic [1:0]    state;
  logic          psel;
  logic          in_idle;
  logic          in_access;
  logic          setup;
  logic          complete;
  logic          violation;

  // Decode of the address presented in the current (setup) cycle.
  logic [IW-1:0] req_idx;
  logic          req_err;

  // Transfer attributes captured in the setup cycle.
  logic [IW-1:0] lat_idx;
  logic          lat_write;
  logic          lat_err;
  logic [31:0]   lat_wdata;

  logic          good_wr;
  logic          good_rd;

  logic [31:0]   regs [NUM_REGS];

  // Only one select bit belongs to this responder; the rest are for its neighbours.
  logic          unused_sel;
  assign unused_sel = ^Pselx;

  assign psel      = Pselx[SEL_IDX];
  assign in_idle   = (state == ST_IDLE);
  assign in_access = (state == ST_ACCESS);

  // A setup is psel without Penable; in ST_ACCESS this doubles as an abort that restarts a transfer.
  assign setup     = psel && !Penable && (in_idle || in_access);
  assign complete  = in_access && Penable;

  // Penable with no preceding setup, or a setup not followed by Penable.
  assign violation = (in_idle && Penable) || (in_access && !Penable);

  assign req_idx   = Paddr[IW+1:2];
  assign req_err   = (Paddr[1:0] != 2'b00) || (Paddr[31:IW+2] != '0);

  assign good_wr   = complete && lat_write && !lat_err;
  assign good_rd   = complete && !lat_write && !lat_err;

  // Two-state transfer FSM; any unknown encoding falls back to idle.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (complete)   state <= ST_IDLE;
          else if (setup) state <= ST_ACCESS;
          else            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the transfer attributes; the access cycle's address/data lines are ignored.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
    end else if (setup) begin
      lat_idx   <= req_idx;
      lat_write <= Pwrite;
      lat_err   <= req_err;
      lat_wdata <= Pwdata;
    end
  end

  // Response is registered from the setup cycle so it is stable for the whole access cycle, zero otherwise.
  // A write committing at this edge cannot overlap a setup, so reading the bank directly is always current.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      Prdata  <= '0;
      Pslverr <= 1'b0;
    end else if (setup) begin
      Pslverr <= req_err;
      Prdata  <= (!Pwrite && !req_err) ? regs[req_idx] : 32'h0;
    end else begin
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end
  end

  // Register bank: a good write lands at the end of its access cycle; reset discards any pending write.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (good_wr) begin
      regs[lat_idx] <= lat_wdata;
    end
  end

  // Completed-transfer counters; errored and aborted transfers are not counted. Both wrap.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (good_rd) rd_count <= rd_count + 16'd1;
      if (good_wr) wr_count <= wr_count + 16'd1;
    end
  end

  // Sticky protocol flag; a new violation takes priority over a clear in the same cycle.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      proto_err <= 1'b0;
    end else if (violation) begin
      proto_err <= 1'b1;
    end else if (err_clr) begin
      proto_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_reg_responder.sv
// Bench for apb_reg_responder: transaction-level reference model, response scoreboard,
// directed scenarios followed by randomized traffic.
module tb_apb_reg_responder;

  localparam int SEL_IDX  = 1;
  localparam int NUM_REGS = 8;
  localparam logic [2:0] SEL_MASK = 3'b010;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pslverr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        proto_err;
  logic        err_clr;

  apb_reg_responder #(.SEL_IDX(SEL_IDX), .NUM_REGS(NUM_REGS)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
    .Pslverr(Pslverr), .rd_count(rd_count), .wr_count(wr_count),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 Hclk = ~Hclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
  } resp_t;

  resp_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state.
  logic [31:0] m_regs [NUM_REGS];
  logic [15:0] m_rd;
  logic [15:0] m_wr;
  logic        m_proto;

  bit          mon_en     = 1'b0;
  bit          junk_zero  = 1'b0;
  bit          prev_setup = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
    m_rd    = 16'h0;
    m_wr    = 16'h0;
    m_proto = 1'b0;
  endtask

  function automatic logic [2:0] other_sel();
    logic [2:0] s;
    s = 3'($urandom) & ~SEL_MASK;
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = {27'h0, 3'($urandom), 2'($urandom_range(1, 3))};
      2:       a = 32'h20 + {27'h0, 3'($urandom), 2'b00};
      default: a = {27'h0, 3'($urandom), 2'b00};
    endcase
    return a;
  endfunction

  // One bus cycle. viol tells the model whether this cycle is a protocol violation.
  task automatic cyc(input logic [2:0] sel, input logic en, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic clr, input logic rst, input logic viol);
    Pselx   = sel;
    Penable = en;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wd;
    err_clr = clr;
    Hreset  = rst;
    @(posedge Hclk);
    #1;
    if (rst)       model_reset();
    else if (viol) m_proto = 1'b1;
    else if (clr)  m_proto = 1'b0;
    chk("proto_err", {31'h0, proto_err}, {31'h0, m_proto});
  endtask

  task automatic check_counters();
    chk("rd_count", {16'h0, rd_count}, {16'h0, m_rd});
    chk("wr_count", {16'h0, wr_count}, {16'h0, m_wr});
  endtask

  // mode 0: normal; 1: an aborted setup immediately restarted by this transfer;
  // 2: reset asserted in the access cycle; 3: setup then abort to idle (no access).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input int mode);
    logic       err;
    logic [2:0] idx;
    logic [2:0] selb;
    logic [2:0] jsel;
    logic [31:0] jaddr;
    logic [31:0] jdata;
    resp_t      r;
    err  = (addr[1:0] != 2'b00) || (addr[31:2] >= NUM_REGS);
    idx  = addr[4:2];
    selb = SEL_MASK | 3'($urandom);
    if (mode == 3) begin
      cyc(selb, 1'b0, wr, addr, wd, 1'b0, 1'b0, 1'b0);
      cyc(other_sel(), 1'b0, 1'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      return;
    end
    if (mode == 1) cyc(selb, 1'b0, 1'($urandom), rand_addr(), $urandom, 1'b0, 1'b0, 1'b0);
    cyc(selb, 1'b0, wr, addr, wd, 1'b0, 1'b0, mode == 1);
    r.rdata  = (wr || err) ? 32'h0 : m_regs[idx];
    r.slverr = err;
    exp_q.push_back(r);
    jsel  = junk_zero ? 3'b000 : 3'($urandom);
    jaddr = junk_zero ? 32'h0 : $urandom;
    jdata = junk_zero ? 32'h0 : $urandom;
    cyc(jsel, 1'b1, 1'($urandom), jaddr, jdata, 1'b0, mode == 2, 1'b0);
    if (mode != 2 && !err) begin
      if (wr) begin
        m_regs[idx] = wd;
        m_wr++;
      end else begin
        m_rd++;
      end
    end
  endtask

  task automatic stray(input logic clr);
    cyc(3'($urandom), 1'b1, 1'($urandom), $urandom, $urandom, clr, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic clr);
    cyc(other_sel(), 1'b0, 1'($urandom), $urandom, $urandom, clr, 1'b0, 1'b0);
  endtask

  // A transfer addressed to a neighbouring responder; its enable cycle looks like a stray enable here.
  task automatic other_xfer();
    logic [2:0] s;
    s = other_sel();
    cyc(s, 1'b0, 1'($urandom), rand_addr(), $urandom, 1'b0, 1'b0, 1'b0);
    cyc(s, 1'b1, 1'($urandom), $urandom, $urandom, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom), 1'b1, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < NUM_REGS; i++) xfer(1'b0, 32'(i * 4), 32'h0, 0);
  endtask

  // Response monitor: access cycles pop the scoreboard, every other cycle must show zeros.
  always @(negedge Hclk) begin
    if (mon_en) begin
      if (prev_setup && Penable) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL resp_q_empty: access cycle with Prdata 0x%08h Pslverr %0b but nothing expected", Prdata, Pslverr);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("Prdata", Prdata, e.rdata);
          chk("Pslverr", {31'h0, Pslverr}, {31'h0, e.slverr});
        end
      end else if (!prev_setup) begin
        chk("Prdata_idle", Prdata, 32'h0);
        chk("Pslverr_idle", {31'h0, Pslverr}, 32'h0);
      end
    end
    prev_setup = Pselx[SEL_IDX] && !Penable && !Hreset;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] d [NUM_REGS];
    model_reset();
    Hreset = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'h0; Pwdata = 32'h0; err_clr = 1'b0;
    do_reset(1);
    mon_en = 1'b1;
    do_reset(1);
    check_counters();
    read_all();

    // Write/read with zeroed access-phase lines.
    junk_zero = 1'b1;
    xfer(1'b1, 32'h8, 32'hDEADBEEF, 0);
    xfer(1'b0, 32'h8, 32'h0, 0);
    junk_zero = 1'b0;
    check_counters();

    // Back-to-back writes then reads over the whole bank.
    do_reset(1);
    for (int i = 0; i < NUM_REGS; i++) begin
      d[i] = $urandom;
      xfer(1'b1, 32'(i * 4), d[i], 0);
    end
    read_all();
    check_counters();

    // Address errors leave the bank and counters alone.
    xfer(1'b1, 32'h20, 32'h12345678, 0);
    xfer(1'b1, 32'h2, 32'h87654321, 0);
    check_counters();
    read_all();

    // Protocol violations and sticky flag behaviour.
    stray(1'b0);
    idle(1'b1);
    xfer(1'b1, 32'hC, 32'hCAFEF00D, 3);
    xfer(1'b0, 32'hC, 32'h0, 0);
    idle(1'b1);
    stray(1'b1);
    idle(1'b0);
    check_counters();

    // Reset during the access cycle drops the write.
    xfer(1'b1, 32'h4, 32'hA5A5A5A5, 2);
    do_reset(1);
    xfer(1'b0, 32'h4, 32'h0, 0);

    // Neighbour-select traffic must not touch this responder.
    xfer(1'b1, 32'h10, 32'h0BADF00D, 0);
    for (int i = 0; i < 6; i++) other_xfer();
    check_counters();
    read_all();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      xfer(1'b1, rand_addr(), $urandom, 0);
      else if (r < 65) xfer(1'b0, rand_addr(), 32'h0, 0);
      else if (r < 72) xfer(1'($urandom), rand_addr(), $urandom, 1);
      else if (r < 78) xfer(1'($urandom), rand_addr(), $urandom, 3);
      else if (r < 83) stray(1'($urandom));
      else if (r < 90) idle(1'($urandom));
      else if (r < 96) other_xfer();
      else             xfer(1'b1, rand_addr(), $urandom, 2);
      check_counters();
    end
    read_all();

    // Reset after random traffic.
    do_reset(2);
    check_counters();
    read_all();

    idle(1'b0);
    idle(1'b0);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL resp_q_drain: got %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
